stopwatch_bcd: RTL
==================

# stopwatch_bcd

Four-digit BCD stopwatch that counts from 00.00 to 99.99 s in hundredths and presents one BCD nibble per digit. It sits directly upstream of the four-digit multiplexed 7-segment display stage. Per-digit values and a decimal-point mask go to that stage's digit decoder, and run/pause is driven from a push-button. All logic runs on the board clock; the display stage keeps its own scan divider.

## Interface
- TICK_DIV, 500000: clock cycles per 1/100 s tick (50 MHz board clock → 100 Hz); must be ≥ 2.
- PRE_W, 20: prescaler width; must satisfy 2^PRE_W > TICK_DIV − 1.
- clk  input  1  board clock; all state changes on rising edge.
- rst  input  1  synchronous, active-high reset.
- btn_ss  input  1  start/stop push-button, asynchronous level, active-high.
- clr  input  1  synchronous clear, active-high level.
- btn_lap  input  1  lap push-button, asynchronous level, active-high; used only with LAP_EN.
- d3  output  4  tens of seconds, BCD.
- d2  output  4  units of seconds, BCD.
- d1  output  4  tenths, BCD.
- d0  output  4  hundredths, BCD.
- dp_mask  output  4  decimal-point enables, active-low; constant 4'b1011 (point after d2).
- running  output  1  high while in state RUN.
- ovf  output  1  sticky; set on wrap 99.99→00.00.

## Operation
- Button conditioning:
  - btn_ss passes through a 2-FF synchronizer, then a rising-edge detector; the result is a one-cycle `ss_pulse`.
  - btn_lap is conditioned the same way into `lap_pulse`.
- FSM states: IDLE, RUN, PAUSE.
  - IDLE → RUN on ss_pulse.
  - RUN → PAUSE on ss_pulse.
  - PAUSE → RUN on ss_pulse.
  - Any state → IDLE when clr = 1.
- Prescaler:
  - Counts 0..TICK_DIV−1 only while in RUN.
  - When it equals TICK_DIV−1 in RUN, it returns to 0 and asserts the internal `tick` for one cycle.
  - Holds its value in PAUSE.
  - Forced to 0 in IDLE.
- BCD chain, on each tick:
  - d0 increments.
  - 9 → 0 carries into d1; d1 9 → 0 carries into d2; d2 9 → 0 carries into d3.
  - d3 at 9 with carry in → 0 and sets ovf.
  - Digit values never exceed 9.
- clr or entry into IDLE: all digits 0, prescaler 0, ovf 0.
- Priority: rst > clr > ss_pulse > tick.
- Reset values: d3..d0 = 0, running = 0, ovf = 0, dp_mask = 4'b1011, FSM = IDLE, synchronizers and edge detectors = 0.

## Timing
- btn_ss rise → ss_pulse: 3 clk edges (two synchronizer stages plus edge register). running changes on the following edge.
- Tick → updated digits: same edge; outputs are registered and the carry chain resolves in one cycle.
- From entering RUN with prescaler 0, the first tick occurs TICK_DIV cycles later.
- Pause/resume: resuming continues from the held prescaler value, so no time is lost or gained.
- ss_pulse and tick in the same cycle while in RUN: the transition to PAUSE wins and no increment occurs.
- clr while RUN: next edge gives IDLE, all digits 0, running = 0; a simultaneous ss_pulse is ignored.
- rst mid-count: all state returns to reset values on that edge.
- A held button produces one pulse only. Bounce produces multiple pulses; debouncing is out of scope for this block.

## Configuration
- STOPWATCH_LAP_EN defined:
  - A lap register holds a display copy of the four digits.
  - In RUN, lap_pulse toggles "frozen". While frozen, d3..d0 show the lap register captured at the freeze edge and counting continues internally.
  - Unfreezing shows live digits on the next edge.
  - clr, rst and ss_pulse from PAUSE clear frozen.
- STOPWATCH_LAP_EN undefined:
  - btn_lap is ignored; no lap logic is synthesized.
  - d3..d0 always show live digits.

## Test plan
- TICK_DIV=4. Assert rst 2 cycles; release → d3..d0 = 0, running = 0, ovf = 0, dp_mask = 4'b1011.
- Press btn_ss (1 cycle high) → running = 1 on the 4th edge; after a further 4·10 cycles → d1 = 1, d0 = 0.
- Run to 99.99 (TICK_DIV=2), then one more tick → all digits 0, ovf = 1, running stays 1.
- At d0 = 3, press btn_ss → PAUSE; wait 20 cycles → d0 still 3. Press again → next tick at the held prescaler phase.
- In RUN, assert clr together with a btn_ss edge → IDLE, digits 0, ovf 0, running 0.
- With STOPWATCH_LAP_EN, lap at 00.05 → outputs hold 00.05 for 30 ticks. Lap again → outputs show the live count 00.35.

Source files
------------

// File: rtl/stopwatch_bcd_if.sv
// Control and display bundle between the stopwatch and its environment.
// master drives buttons/clear; slave (the stopwatch) drives digits and status.
interface stopwatch_bcd_if;
  localparam int unsigned DIG_W = 4;

  logic             btn_ss;
  logic             clr;
  logic             btn_lap;
  logic [DIG_W-1:0] d3;
  logic [DIG_W-1:0] d2;
  logic [DIG_W-1:0] d1;
  logic [DIG_W-1:0] d0;
  logic [DIG_W-1:0] dp_mask;
  logic             running;
  logic             ovf;

  modport master (
    output btn_ss, clr, btn_lap,
    input  d3, d2, d1, d0, dp_mask, running, ovf
  );

  modport slave (
    input  btn_ss, clr, btn_lap,
    output d3, d2, d1, d0, dp_mask, running, ovf
  );
endinterface

// File: rtl/stopwatch_bcd.sv
// Four-digit BCD stopwatch (00.00..99.99 s) with start/stop, clear and sticky overflow.
// Optional lap-freeze display enabled by defining STOPWATCH_LAP_EN.
module stopwatch_bcd #(
  parameter int unsigned TICK_DIV = 500000,
  parameter int unsigned PRE_W    = 20
) (
  input logic            clk,
  input logic            rst,
  stopwatch_bcd_if.slave bus
);
  localparam int unsigned DIG_W  = 4;
  localparam int unsigned N_DIG  = 4;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);
  localparam logic [DIG_W-1:0] DP_CONST = 4'b1011;

  typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;

  state_t                       state, state_next;
  logic [PRE_W-1:0]             pre, pre_next;
  logic [N_DIG-1:0][DIG_W-1:0]  cnt, cnt_next;
  logic [N_DIG-1:0][DIG_W-1:0]  shown;
  logic                         ovf, ovf_next;
  logic                         running;
  logic [DIG_W-1:0]             dp_mask;
  logic [2:0]                   ss_sync;
  logic                         ss_pulse;
  logic                         carry;

  // Two-stage synchronizer plus registered rising-edge detect.
  always_ff @(posedge clk) begin
    if (rst) begin
      ss_sync  <= '0;
      ss_pulse <= 1'b0;
    end else begin
      ss_sync  <= {ss_sync[1:0], bus.btn_ss};
      ss_pulse <= ss_sync[1] & ~ss_sync[2];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      pre     <= '0;
      cnt     <= '0;
      ovf     <= 1'b0;
      running <= 1'b0;
      dp_mask <= DP_CONST;
    end else begin
      state   <= state_next;
      pre     <= pre_next;
      cnt     <= cnt_next;
      ovf     <= ovf_next;
      running <= (state_next == RUN);
      dp_mask <= DP_CONST;
    end
  end

  // Start/stop wins over a coincident tick; the prescaler holds on that edge.
  always_comb begin
    state_next = state;
    pre_next   = pre;
    cnt_next   = cnt;
    ovf_next   = ovf;
    carry      = 1'b0;
    if (bus.clr) begin
      state_next = IDLE;
      pre_next   = '0;
      cnt_next   = '0;
      ovf_next   = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          pre_next = '0;
          cnt_next = '0;
          ovf_next = 1'b0;
          if (ss_pulse) state_next = RUN;
        end
        RUN: begin
          if (ss_pulse) begin
            state_next = PAUSE;
          end else if (pre == PRE_LAST) begin
            pre_next = '0;
            carry    = 1'b1;
            for (int i = 0; i < N_DIG; i++) begin
              if (carry) begin
                if (cnt[i] == 4'd9) begin
                  cnt_next[i] = '0;
                end else begin
                  cnt_next[i] = cnt[i] + 4'd1;
                  carry       = 1'b0;
                end
              end
            end
            if (carry) ovf_next = 1'b1;
          end else begin
            pre_next = pre + 1'b1;
          end
        end
        PAUSE: begin
          if (ss_pulse) state_next = RUN;
        end
        default: state_next = IDLE;
      endcase
    end
  end

`ifdef STOPWATCH_LAP_EN
  logic [2:0]                  lap_sync;
  logic                        lap_pulse;
  logic                        frozen, frozen_next;
  logic [N_DIG-1:0][DIG_W-1:0] lap_q, lap_next;
  logic [N_DIG-1:0][DIG_W-1:0] disp, disp_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      lap_sync  <= '0;
      lap_pulse <= 1'b0;
      frozen    <= 1'b0;
      lap_q     <= '0;
      disp      <= '0;
    end else begin
      lap_sync  <= {lap_sync[1:0], bus.btn_lap};
      lap_pulse <= lap_sync[1] & ~lap_sync[2];
      frozen    <= frozen_next;
      lap_q     <= lap_next;
      disp      <= disp_next;
    end
  end

  // Freeze captures the digits being written on the same edge.
  always_comb begin
    frozen_next = frozen;
    lap_next    = lap_q;
    disp_next   = cnt_next;
    if (state_next == IDLE) begin
      frozen_next = 1'b0;
    end else if (state == PAUSE && ss_pulse) begin
      frozen_next = 1'b0;
    end else if (state == RUN && lap_pulse) begin
      frozen_next = ~frozen;
      if (!frozen) lap_next = cnt_next;
    end
    if (frozen_next) disp_next = lap_next;
  end

  assign shown = disp;
`else
  logic unused_lap;
  assign unused_lap = bus.btn_lap;
  assign shown      = cnt;
`endif

  assign bus.d0      = shown[0];
  assign bus.d1      = shown[1];
  assign bus.d2      = shown[2];
  assign bus.d3      = shown[3];
  assign bus.dp_mask = dp_mask;
  assign bus.running = running;
  assign bus.ovf     = ovf;
endmodule
